// File: rtl/snake_engine_if.sv
// Control, pixel-query and status signals between the game/VGA logic and snake_engine.
interface snake_engine_if #(
    parameter int unsigned MAX_LEN = 32
);
    localparam int unsigned SW = $clog2(MAX_LEN) + 1;

    logic          start;
    logic          update;
    logic [4:0]    direction;
    logic          grow;
    logic [9:0]    xCount;
    logic [9:0]    yCount;
    logic          snakeHead;
    logic          snakeBody;
    logic [SW-1:0] size;
    logic          busy;
    logic          game_over;

    modport master (
        output start, update, direction, grow, xCount, yCount,
        input  snakeHead, snakeBody, size, busy, game_over
    );

    modport slave (
        input  start, update, direction, grow, xCount, yCount,
        output snakeHead, snakeBody, size, busy, game_over
    );
endinterface

// File: rtl/snake_engine.sv
// Snake segment tracker: moves, grows, detects walls and self-collision, flags head/body pixels.
// Define WRAP_EN to make the head wrap around the screen edges instead of dying at a wall.
module snake_engine #(
    parameter int unsigned MAX_LEN  = 32,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned SEG      = 10,
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned START_X  = 300,
    parameter int unsigned START_Y  = 300,
    parameter int unsigned PARK_X   = 700,
    parameter int unsigned PARK_Y   = 500
) (
    input logic           VGA_clk,
    input logic           reset,
    snake_engine_if.slave bus
);
    localparam int unsigned CW  = 10;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned AW  = CW + 2;
    localparam int unsigned KW  = $clog2(MAX_LEN);
    localparam int unsigned SW  = KW + 1;

    localparam logic signed [AW-1:0] XMAX = AW'(H_RES - SEG);
    localparam logic signed [AW-1:0] YMAX = AW'(V_RES - SEG);

    localparam logic [4:0] DIR_UP    = 5'd1;
    localparam logic [4:0] DIR_LEFT  = 5'd2;
    localparam logic [4:0] DIR_DOWN  = 5'd3;
    localparam logic [4:0] DIR_RIGHT = 5'd4;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } coord_t;

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DEAD} state_t;

    state_t        state_q, state_d;
    coord_t        seg_q [MAX_LEN];
    logic [SW-1:0] size_q;
    logic [4:0]    heading_q;
    logic          grow_pend_q;
    logic [KW-1:0] k_q;
    logic          head_hit_q, body_hit_q, busy_q, game_over_q;

    logic                 is_move_c, reversal_c, move_c, shift_c, grow_c, oob_c;
    logic                 hit_c, last_c, head_hit_c, body_hit_c;
    logic [4:0]           dir_c;
    logic signed [AW-1:0] nx_c, ny_c;
    coord_t               new_head_c;

    // Strict inside test of one SEG-sized square
    function automatic logic pix_hit(input coord_t c, input logic [CW-1:0] px,
                                     input logic [CW-1:0] py);
        logic [CW:0] x0, y0;
        x0 = {1'b0, c.x};
        y0 = {1'b0, c.y};
        return ({1'b0, px} > x0) && ({1'b0, px} < x0 + CW1'(SEG)) &&
               ({1'b0, py} > y0) && ({1'b0, py} < y0 + CW1'(SEG));
    endfunction

    // Direction filtering and candidate head position
    always_comb begin
        is_move_c  = (bus.direction == DIR_UP) || (bus.direction == DIR_LEFT) ||
                     (bus.direction == DIR_DOWN) || (bus.direction == DIR_RIGHT);
        reversal_c = (bus.direction == DIR_UP    && heading_q == DIR_DOWN)  ||
                     (bus.direction == DIR_DOWN  && heading_q == DIR_UP)    ||
                     (bus.direction == DIR_LEFT  && heading_q == DIR_RIGHT) ||
                     (bus.direction == DIR_RIGHT && heading_q == DIR_LEFT);
        dir_c = (is_move_c && !reversal_c) ? bus.direction : heading_q;
        nx_c  = $signed({2'b00, seg_q[0].x});
        ny_c  = $signed({2'b00, seg_q[0].y});
        case (dir_c)
            DIR_UP:    ny_c = ny_c - $signed(AW'(SEG));
            DIR_DOWN:  ny_c = ny_c + $signed(AW'(SEG));
            DIR_LEFT:  nx_c = nx_c - $signed(AW'(SEG));
            DIR_RIGHT: nx_c = nx_c + $signed(AW'(SEG));
            default: ;
        endcase
`ifdef WRAP_EN
        oob_c = 1'b0;
        if (nx_c[AW-1])      nx_c = XMAX;
        else if (nx_c > XMAX) nx_c = '0;
        if (ny_c[AW-1])      ny_c = YMAX;
        else if (ny_c > YMAX) ny_c = '0;
`else
        oob_c = nx_c[AW-1] || (nx_c > XMAX) || ny_c[AW-1] || (ny_c > YMAX);
`endif
        new_head_c.x = nx_c[CW-1:0];
        new_head_c.y = ny_c[CW-1:0];

        move_c  = (state_q == RUN) && bus.start && bus.update && is_move_c;
        shift_c = move_c && !oob_c;
        grow_c  = shift_c && grow_pend_q && (size_q < SW'(MAX_LEN));

        hit_c  = (seg_q[k_q] == seg_q[0]);
        last_c = ({1'b0, k_q} == size_q - SW'(1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!bus.start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = RUN;
                RUN:   if (move_c) state_d = oob_c ? DEAD : CHECK;
                CHECK: begin
                    if (hit_c)       state_d = DEAD;
                    else if (last_c) state_d = RUN;
                end
                DEAD:    state_d = DEAD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Segment storage, length, heading and collision index
    always_ff @(posedge VGA_clk) begin
        if (reset || !bus.start) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_q[i].x <= CW'(START_X - i * SEG);
                    seg_q[i].y <= CW'(START_Y);
                end else begin
                    seg_q[i].x <= CW'(PARK_X);
                    seg_q[i].y <= CW'(PARK_Y);
                end
            end
            size_q      <= SW'(INIT_LEN);
            heading_q   <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            k_q         <= KW'(1);
        end else begin
            if (shift_c) begin
                seg_q[0] <= new_head_c;
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    if (SW'(i) < size_q || (grow_c && SW'(i) == size_q))
                        seg_q[i] <= seg_q[i-1];
                end
                heading_q <= dir_c;
                if (grow_c) size_q <= size_q + SW'(1);
            end
            // A move consumes the pending request; a pulse on the same cycle re-arms it
            if (shift_c)                             grow_pend_q <= bus.grow;
            else if (bus.grow && state_q != IDLE) grow_pend_q <= 1'b1;
            if (move_c)                 k_q <= KW'(1);
            else if (state_q == CHECK) k_q <= k_q + KW'(1);
        end
    end

    // Pixel hit evaluation over live segments only
    always_comb begin
        head_hit_c = pix_hit(seg_q[0], bus.xCount, bus.yCount);
        body_hit_c = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (SW'(i) < size_q && pix_hit(seg_q[i], bus.xCount, bus.yCount))
                body_hit_c = 1'b1;
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            head_hit_q  <= 1'b0;
            body_hit_q  <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            head_hit_q  <= head_hit_c;
            body_hit_q  <= body_hit_c;
            busy_q      <= (state_d == CHECK);
            game_over_q <= (state_d == DEAD);
        end
    end

    assign bus.snakeHead = head_hit_q;
    assign bus.snakeBody = body_hit_q;
    assign bus.size      = size_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: stimulus queues expected outputs, a negedge monitor checks them.
module tb_snake_engine;
    localparam int K_HEAD = 0;
    localparam int K_BODY = 1;
    localparam int K_SIZE = 2;
    localparam int K_BUSY = 3;
    localparam int K_GO   = 4;
    localparam int K_VAL  = 5;

    localparam logic [4:0] D_UP    = 5'd1;
    localparam logic [4:0] D_LEFT  = 5'd2;
    localparam logic [4:0] D_DOWN  = 5'd3;
    localparam logic [4:0] D_RIGHT = 5'd4;
    localparam logic [4:0] D_PAUSE = 5'd7;

    typedef struct {
        int    kind;
        int    exp;
        int    act;
        string name;
    } chk_t;

    logic clk = 1'b0;
    logic reset;
    chk_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    snake_engine_if #(.MAX_LEN(32)) bus ();

    snake_engine dut (
        .VGA_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Monitor: drains every queued expectation against the settled outputs
    always @(negedge clk) begin : monitor
        chk_t c;
        int   a;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.kind)
                K_HEAD:  a = int'(bus.snakeHead);
                K_BODY:  a = int'(bus.snakeBody);
                K_SIZE:  a = int'(bus.size);
                K_BUSY:  a = int'(bus.busy);
                K_GO:    a = int'(bus.game_over);
                default: a = c.act;
            endcase
            n_total++;
            if (a == c.exp) n_pass++;
            else $display("FAIL %s: got %0d expected %0d", c.name, a, c.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input int kind, input int exp, input string name);
        chk_t c;
        c.kind = kind; c.exp = exp; c.act = 0; c.name = name;
        sb.push_back(c);
    endtask

    task automatic chk_val(input int act, input int exp, input string name);
        chk_t c;
        c.kind = K_VAL; c.exp = exp; c.act = act; c.name = name;
        sb.push_back(c);
    endtask

    task automatic probe(input int px, input int py, input int hexp, input int bexp,
                         input string name);
        bus.xCount = 10'(px);
        bus.yCount = 10'(py);
        tick();
        chk_out(K_HEAD, hexp, {name, "_head"});
        chk_out(K_BODY, bexp, {name, "_body"});
    endtask

    task automatic move(input logic [4:0] d);
        bus.direction = d;
        bus.update    = 1'b1;
        tick();
        bus.update    = 1'b0;
        bus.direction = D_PAUSE;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk_val(0, 1, {name, "_timeout"});
    endtask

    task automatic grow_move(input logic [4:0] d);
        bus.grow = 1'b1;
        tick();
        bus.grow = 1'b0;
        move(d);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        bus.start = 1'b0; bus.update = 1'b0; bus.grow = 1'b0;
        bus.direction = D_PAUSE; bus.xCount = '0; bus.yCount = '0;
        tick(); tick();
        chk_out(K_SIZE, 4, "rst_size");
        chk_out(K_BUSY, 0, "rst_busy");
        chk_out(K_GO,   0, "rst_go");
        chk_out(K_HEAD, 0, "rst_head");
        n_total++;
        if (int'(bus.size) == 4) n_pass++;
        else $display("FAIL rst_size_now: got %0d expected 4", bus.size);

        // Initial body: head (300,300), body at x=290,280,270
        reset = 1'b0;
        bus.start = 1'b1;
        probe(305, 305, 1, 0, "t1_in");
        probe(295, 305, 0, 1, "t1_seg1");
        probe(300, 305, 0, 0, "t1_xedge");
        probe(305, 310, 0, 0, "t1_yedge");
        probe(275, 305, 0, 1, "t1_seg3");
        probe(265, 305, 0, 0, "t1_past_tail");
        chk_out(K_GO, 0, "t1_go");

        // Straight moves right; busy for size-1 = 3 cycles
        move(D_RIGHT);
        chk_out(K_BUSY, 1, "t2_busy_a"); tick();
        chk_out(K_BUSY, 1, "t2_busy_b"); tick();
        chk_out(K_BUSY, 1, "t2_busy_c"); tick();
        chk_out(K_BUSY, 0, "t2_busy_end");
        move(D_RIGHT);
        move(D_RIGHT);                     // lands in CHECK, dropped
        wait_idle("t2_w1");
        move(D_RIGHT); wait_idle("t2_w2");
        move(D_RIGHT); wait_idle("t2_w3");
        probe(345, 305, 1, 0, "t2_head340");
        probe(335, 305, 0, 1, "t2_seg1");
        move(D_PAUSE);
        chk_out(K_BUSY, 0, "t2_pause_busy");
        probe(345, 305, 1, 0, "t2_pause_head");

        // Reversal ignored, then turn up
        move(D_LEFT); wait_idle("t3_w1");
        probe(355, 305, 1, 0, "t3_rev");
        move(D_UP); wait_idle("t3_w2");
        probe(355, 295, 1, 0, "t3_up");
        probe(355, 305, 0, 1, "t3_up_body");

        // Growth: tail (330,300) survives the move
        grow_move(D_UP);
        chk_out(K_SIZE, 5, "t4_size5");
        wait_idle("t4_w1");
        probe(335, 305, 0, 1, "t4_tail_kept");
        probe(355, 285, 1, 0, "t4_head");
        bus.grow = 1'b1; tick(); tick(); tick(); bus.grow = 1'b0;
        move(D_RIGHT);
        chk_out(K_SIZE, 6, "t4_multi_grow");
        wait_idle("t4_w2");
        move(D_RIGHT);
        chk_out(K_SIZE, 6, "t4_no_grow");
        wait_idle("t4_w3");
        for (int i = 0; i < 40; i++) begin
            grow_move(i < 20 ? D_UP : D_RIGHT);
            wait_idle("t4_sat");
        end
        chk_out(K_SIZE, 32, "t4_size_sat");
        chk_out(K_GO, 0, "t4_alive");
        n_total++;
        if (int'(bus.size) == 32) n_pass++;
        else $display("FAIL t4_size_sat_now: got %0d expected 32", bus.size);
        probe(575, 85, 1, 0, "t4_head570_80");

        // Restart, then self-collision at size 5
        bus.start = 1'b0;
        tick();
        chk_out(K_GO,   0, "t6_restart_go");
        chk_out(K_SIZE, 4, "t6_restart_size");
        chk_out(K_BUSY, 0, "t6_restart_busy");
        bus.start = 1'b1;
        probe(305, 305, 1, 0, "t6_reinit");
        probe(705, 505, 0, 0, "t6_parked");
        grow_move(D_RIGHT); wait_idle("t6_w1");
        move(D_UP);   wait_idle("t6_w2");
        move(D_LEFT); wait_idle("t6_w3");
        move(D_DOWN);
        n = 0;
        while (!bus.game_over && n < 10) begin
            tick();
            n++;
        end
        n_total++;
        if (n == 4) n_pass++;
        else $display("FAIL t6_death_latency: got %0d expected 4", n);
        n_total++;
        if (bus.game_over == 1'b1) n_pass++;
        else $display("FAIL t6_dead_now: got %0d expected 1", bus.game_over);
        chk_out(K_GO, 1, "t6_dead");
        move(D_UP);
        probe(305, 305, 1, 1, "t6_frozen");
        chk_out(K_GO, 1, "t6_still_dead");
        bus.start = 1'b0;
        tick();
        chk_out(K_GO, 0, "t6_cleared");
        bus.start = 1'b1;
        tick();

        // Drive head to the left wall at (0,300)
        move(D_UP); wait_idle("t5_w1");
        for (int i = 0; i < 30; i++) begin
            move(D_LEFT);
            wait_idle("t5_left");
        end
        move(D_DOWN); wait_idle("t5_w2");
        probe(5, 305, 1, 0, "t5_at_wall");
        move(D_LEFT);
`ifdef WRAP_EN
        wait_idle("t5_wrap");
        chk_out(K_GO, 0, "t5_wrap_alive");
        probe(635, 305, 1, 0, "t5_wrap_head");
        probe(5, 305, 0, 1, "t5_wrap_body");
`else
        chk_out(K_GO,   1, "t5_wall_dead");
        chk_out(K_BUSY, 0, "t5_wall_busy");
        probe(5, 305, 1, 0, "t5_head_kept");
        probe(635, 305, 0, 0, "t5_no_wrap");
`endif

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
